wb_ext_responder: RTL and testbench
===================================

# wb_ext_responder

Wishbone B3 slave that terminates one tile's external bus, the `wb_ext_*` port group each compute tile drives as master. It sits outside the tile in the system top or testbench, one instance per tile. It backs a word-addressed SRAM with configurable wait states, supports registered-feedback incrementing and wrapping bursts, and answers error and retry.

## Interface
Parameters:
- `MEM_BASE`, 32'h0: byte address of word 0.
- `MEM_WORDS`, 1024: SRAM depth in 32-bit words; a power of two, at least 16.
- `WAIT_STATES`, 1: extra cycles before the first ack of a cycle; range 0..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_adr_i`  in  32  byte address.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte enables; bit n selects `dat[8n+7:8n]`.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  1 = write.
- `wb_cab_i`  in  1  ignored.
- `wb_cti_i`  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- `wb_bte_i`  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- `rty_req`  in  1  when high, a new request is answered with retry.
- `wb_ack_o`  out  1  registered ack.
- `wb_err_o`  out  1  registered error.
- `wb_rty_o`  out  1  registered retry.
- `wb_dat_o`  out  32  read data; valid while `wb_ack_o` is high.

## Operation
- Request: `wb_cyc_i & wb_stb_i`. A request is in range when `wb_adr_i[1:0]==0` and `MEM_BASE <= adr < MEM_BASE + 4*MEM_WORDS`. Word index is `(adr - MEM_BASE) >> 2`.
- States:
  - IDLE: on a new request, priority is (1) out of range -> RESP_ERR; (2) `rty_req` -> RESP_RTY; (3) otherwise latch the address in `cur_adr`, load `wait_cnt = WAIT_STATES`, go to WAIT.
  - WAIT: decrement `wait_cnt`. At 0, go to ACK.
  - ACK: `wb_ack_o` = 1 for exactly this cycle.
    - Write: memory bytes with `wb_sel_i` set take `wb_dat_i` in this cycle. Bytes with `wb_sel_i` clear are unchanged.
    - Read: `wb_dat_o = mem[cur_adr]`.
    - Next state: if the sampled `wb_cti_i` is 010 and `wb_stb_i` is high, go to BURST with `cur_adr = next(cur_adr)`. Otherwise go to IDLE.
  - BURST: ack every cycle while `wb_cyc_i & wb_stb_i`; each beat acts as in ACK on `cur_adr`, then advances it.
    - A beat with `wb_cti_i == 111` is acked, then the state goes to IDLE.
    - `wb_stb_i` low (burst pause) holds the state with no ack.
    - If `cur_adr` leaves the range, that beat gets `wb_err_o` instead of ack, then IDLE.
  - RESP_ERR / RESP_RTY: assert the matching output for one cycle, then go to IDLE.
- Address advance `next()`, with `a = cur_adr`:
  - bte 00: `a + 4`, full 32-bit increment.
  - bte 01: `a[3:2]` increments modulo 4; upper bits unchanged.
  - bte 10: `a[4:2]` increments modulo 8; upper bits unchanged.
  - bte 11: `a[5:2]` increments modulo 16; upper bits unchanged.
- Read data for a burst beat comes from the predicted `cur_adr`, not from `wb_adr_i`.
- `wb_cyc_i` low in any state: go to IDLE next cycle with no ack/err/rty. A pending write is not performed.
- At most one of ack/err/rty is high in any cycle.
- IDLE asserts nothing, so two classic requests back to back always have at least one idle cycle between their acks.
- `wb_rty_o` and `wb_err_o` are never asserted for an in-range request while `rty_req` is low.

## Timing
- Reset (`rst` low, asynchronous): state IDLE; `wb_ack_o`, `wb_err_o`, `wb_rty_o` = 0; `wb_dat_o` = 32'h0; `wait_cnt` = 0. Memory contents are undefined.
- Classic request sampled at edge T: ack is high in cycle T+1+WAIT_STATES. With WAIT_STATES=0 that is the cycle after sampling.
- Burst of N beats: first ack as for classic, then one ack per cycle. The total is WAIT_STATES+N cycles from sample to last ack, with no stalls and no master pauses.
- Error or retry response: high in cycle T+1, independent of WAIT_STATES.
- Write data is committed at the edge that ends the ack cycle. A read at the immediately following request returns the new data.
- `wb_dat_o` holds its last value outside ack cycles.

## Test plan
- Reset with inputs toggling, then release -> ack/err/rty = 0, `wb_dat_o` = 0.
- WAIT_STATES=2: classic write of 32'hDEADBEEF, sel 4'b0101, to MEM_BASE+8, over the prior value 32'h11223344; then a classic read of the same address -> first ack 3 cycles after the first request is sampled; read returns 32'h11AD33EF, also after 3 cycles.
- WAIT_STATES=0: wrap-4 read burst starting at MEM_BASE+8, four beats, last beat cti=111 -> 4 consecutive acks returning words 2, 3, 0, 1; state is IDLE the cycle after the last ack.
- Linear burst that starts at the last word, cti held at 010 -> first beat acked, second beat gets `wb_err_o`, then no further response.
- Request to MEM_BASE+2 (misaligned), then `rty_req`=1 with a valid address -> err for 1 cycle, then rty for 1 cycle; memory unchanged.
- WAIT_STATES=3: `wb_cyc_i` dropped during WAIT on a write -> no ack, target word unchanged; the next request is served normally.

Source files
------------

// File: rtl/wb_ext_responder.sv
// Wishbone B3 slave terminating one tile's external bus: word SRAM with wait states,
// registered-feedback incrementing/wrapping bursts, and error/retry answers.
module wb_ext_responder #(
    parameter logic [31:0] MEM_BASE    = 32'h0,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic        wb_cab_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    input  logic        rty_req,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] wb_dat_o,
    output logic [2:0]  fsm_state
);
    localparam int          IW   = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        ACK      = 3'd2,
        BURST    = 3'd3,
        RESP_ERR = 3'd4,
        RESP_RTY = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] cur_adr;
    logic [3:0]  wait_cnt;
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] adv_adr;
    logic        adv_ok;
    logic        mem_we;
    logic        unused_cab;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - MEM_BASE;
        return (a[1:0] == 2'b00) && (a >= MEM_BASE) && (off < SPAN);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'((a - MEM_BASE) >> 2);
    endfunction

    function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
        logic [31:0] n;
        n = a;
        case (bte)
            2'b00:   n = a + 32'd4;
            2'b01:   n[3:2] = a[3:2] + 2'd1;
            2'b10:   n[4:2] = a[4:2] + 3'd1;
            default: n[5:2] = a[5:2] + 4'd1;
        endcase
        return n;
    endfunction

    assign adv_adr    = next_adr(cur_adr, wb_bte_i);
    assign adv_ok     = in_range(adv_adr);
    assign fsm_state  = state;
    assign unused_cab = wb_cab_i;
    // A write beat completes at the edge that ends its ack cycle, only if the master is still there.
    assign mem_we     = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) mem[word_idx(cur_adr)][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cur_adr  <= 32'h0;
            wait_cnt <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_rty_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_rty_o <= 1'b0;
            if (!wb_cyc_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (wb_stb_i) begin
                            if (!in_range(wb_adr_i)) begin
                                state    <= RESP_ERR;
                                wb_err_o <= 1'b1;
                            end else if (rty_req) begin
                                state    <= RESP_RTY;
                                wb_rty_o <= 1'b1;
                            end else begin
                                cur_adr <= wb_adr_i;
                                if (WAIT_STATES == 0) begin
                                    state    <= ACK;
                                    wb_ack_o <= 1'b1;
                                    wb_dat_o <= mem[word_idx(wb_adr_i)];
                                end else begin
                                    // Counted one short so the ack lands WAIT_STATES cycles late.
                                    state    <= WAIT;
                                    wait_cnt <= 4'(WAIT_STATES - 1);
                                end
                            end
                        end
                    end
                    WAIT: begin
                        if (wait_cnt == 4'd0) begin
                            state    <= ACK;
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= mem[word_idx(cur_adr)];
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    ACK: begin
                        if (wb_stb_i && wb_cti_i == 3'b010) begin
                            state    <= BURST;
                            cur_adr  <= adv_adr;
                            wb_ack_o <= adv_ok;
                            wb_err_o <= !adv_ok;
                            if (adv_ok) wb_dat_o <= mem[word_idx(adv_adr)];
                        end else begin
                            state <= IDLE;
                        end
                    end
                    BURST: begin
                        if (wb_ack_o || wb_err_o) begin
                            if (!wb_stb_i) begin
                                state <= BURST;
                            end else if (wb_err_o || wb_cti_i == 3'b111) begin
                                state <= IDLE;
                            end else begin
                                cur_adr  <= adv_adr;
                                wb_ack_o <= adv_ok;
                                wb_err_o <= !adv_ok;
                                if (adv_ok) wb_dat_o <= mem[word_idx(adv_adr)];
                            end
                        end else if (wb_stb_i) begin
                            // Master resumed after a pause: re-present the pending beat.
                            wb_ack_o <= in_range(cur_adr);
                            wb_err_o <= !in_range(cur_adr);
                            if (in_range(cur_adr)) wb_dat_o <= mem[word_idx(cur_adr)];
                        end
                    end
                    RESP_ERR: state <= IDLE;
                    RESP_RTY: state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wb_ext_responder.sv
// Directed bench for wb_ext_responder: three instances with WAIT_STATES 2, 0 and 3,
// each scenario task checks its own results against hand-computed values.
module tb_wb_ext_responder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    logic [2:0][31:0] adr, dat_w, dout;
    logic [2:0][3:0]  sel;
    logic [2:0][2:0]  cti, st;
    logic [2:0][1:0]  bte;
    logic [2:0]       cyc, stb, we, cab, rty_req, ack, err, rty;
    int n_checks = 0;
    int n_fail = 0;
    logic [2:0]  b_resp [8];
    logic [31:0] b_dat  [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_ext_responder #(
            .MEM_BASE(BASE), .MEM_WORDS(16), .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 3))
        ) dut (
            .clk(clk), .rst(rst),
            .wb_adr_i(adr[g]), .wb_dat_i(dat_w[g]), .wb_sel_i(sel[g]),
            .wb_cyc_i(cyc[g]), .wb_stb_i(stb[g]), .wb_we_i(we[g]), .wb_cab_i(cab[g]),
            .wb_cti_i(cti[g]), .wb_bte_i(bte[g]), .rty_req(rty_req[g]),
            .wb_ack_o(ack[g]), .wb_err_o(err[g]), .wb_rty_o(rty[g]), .wb_dat_o(dout[g]),
            .fsm_state(st[g])
        );
    end

    function automatic logic [2:0] get_resp(input int i);
        return {ack[i], err[i], rty[i]};
    endfunction

    function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [1:0] b);
        case (b)
            2'b00:   return a + 32'd4;
            2'b01:   return {a[31:4], 2'(a[3:2] + 2'd1), a[1:0]};
            2'b10:   return {a[31:5], 3'(a[4:2] + 3'd1), a[1:0]};
            default: return {a[31:6], 4'(a[5:2] + 4'd1), a[1:0]};
        endcase
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0; dat_w[i] = '0; sel[i] = '0; cti[i] = '0; bte[i] = '0;
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; cab[i] = 1'b0; rty_req[i] = 1'b0;
        end
    endtask

    task automatic classic(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output logic [2:0] r, output logic [31:0] rd);
        adr[i] = a; dat_w[i] = d; sel[i] = s; we[i] = w; cti[i] = 3'b000; bte[i] = 2'b00;
        cyc[i] = 1'b1; stb[i] = 1'b1;
        lat = 0; r = 3'b000;
        while (r == 3'b000 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            r = get_resp(i);
        end
        rd = dout[i];
        @(posedge clk); #1;
        cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    endtask

    task automatic burst(input int i, input logic [31:0] a0, input logic [1:0] b, input int n,
                         input logic end_last, output int lat);
        logic [31:0] a;
        logic [2:0]  r;
        a = a0;
        for (int k = 0; k < 8; k++) begin b_resp[k] = 3'b000; b_dat[k] = '0; end
        adr[i] = a0; bte[i] = b; we[i] = 1'b0; sel[i] = 4'hF;
        cti[i] = (n == 1 && end_last) ? 3'b111 : 3'b010;
        cyc[i] = 1'b1; stb[i] = 1'b1;
        lat = 0; r = 3'b000;
        while (r == 3'b000 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            r = get_resp(i);
        end
        b_resp[0] = r; b_dat[0] = dout[i];
        for (int k = 1; k < n; k++) begin
            @(posedge clk); #1;
            a = tb_next(a, b);
            adr[i] = a;
            cti[i] = (k == n - 1 && end_last) ? 3'b111 : 3'b010;
            b_resp[k] = get_resp(i); b_dat[k] = dout[i];
        end
        @(posedge clk); #1;
        cyc[i] = 1'b0; stb[i] = 1'b0; cti[i] = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                adr[i] = BASE + 32'(4 * k); cyc[i] = k[0]; stb[i] = 1'b1; we[i] = ~k[0];
                dat_w[i] = 32'hFFFF_0000 ^ 32'(k); sel[i] = 4'hF; rty_req[i] = k[1];
            end
            @(posedge clk); #1;
        end
        idle_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (get_resp(i) !== 3'b000) begin n_fail++; $display("FAIL reset_resp[%0d]: got %b expected 000", i, get_resp(i)); end
            n_checks++;
            if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL reset_dat[%0d]: got %h expected 00000000", i, dout[i]); end
            n_checks++;
            if (st[i] !== 3'd0) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d expected 0", i, st[i]); end
        end
    endtask

    task automatic test_classic_ws2();
        int lat;
        logic [2:0] r;
        logic [31:0] d;
        classic(0, 1'b1, BASE + 32'd8, 32'h1122_3344, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b100) begin n_fail++; $display("FAIL ws2_prewrite_resp: got %b expected 100", r); end
        classic(0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'b0101, lat, r, d);
        n_checks++;
        if (r !== 3'b100 || lat !== 3) begin n_fail++; $display("FAIL ws2_write: resp %b lat %0d expected 100 lat 3", r, lat); end
        classic(0, 1'b0, BASE + 32'd8, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b100 || lat !== 3) begin n_fail++; $display("FAIL ws2_read: resp %b lat %0d expected 100 lat 3", r, lat); end
        n_checks++;
        if (d !== 32'h11AD_33EF) begin n_fail++; $display("FAIL ws2_read_data: got %h expected 11ad33ef", d); end
    endtask

    task automatic test_wrap_burst();
        int lat;
        logic [2:0] r;
        logic [31:0] d;
        logic [31:0] wv [4];
        wv = '{32'hC0DE_0000, 32'hC0DE_1111, 32'hC0DE_2222, 32'hC0DE_3333};
        for (int k = 0; k < 4; k++) begin
            classic(1, 1'b1, BASE + 32'(4 * k), wv[k], 4'hF, lat, r, d);
            n_checks++;
            if (r !== 3'b100 || lat !== 1) begin n_fail++; $display("FAIL ws0_write[%0d]: resp %b lat %0d expected 100 lat 1", k, r, lat); end
        end
        burst(1, BASE + 32'd8, 2'b01, 4, 1'b1, lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL wrap_first_latency: got %0d expected 1", lat); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (b_resp[k] !== 3'b100 || b_dat[k] !== wv[(k + 2) % 4]) begin
                n_fail++;
                $display("FAIL wrap_beat[%0d]: resp %b data %h expected 100 data %h", k, b_resp[k], b_dat[k], wv[(k + 2) % 4]);
            end
        end
        n_checks++;
        if (st[1] !== 3'd0 || ack[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_end_idle: state %0d ack %b expected 0 0", st[1], ack[1]); end
    endtask

    task automatic test_linear_end();
        int lat;
        logic [2:0] r;
        logic [31:0] d;
        classic(1, 1'b1, BASE + 32'd60, 32'h0F0F_5A5A, 4'hF, lat, r, d);
        burst(1, BASE + 32'd60, 2'b00, 2, 1'b0, lat);
        n_checks++;
        if (b_resp[0] !== 3'b100 || b_dat[0] !== 32'h0F0F_5A5A) begin
            n_fail++; $display("FAIL linear_last_beat: resp %b data %h expected 100 data 0f0f5a5a", b_resp[0], b_dat[0]);
        end
        n_checks++;
        if (b_resp[1] !== 3'b010) begin n_fail++; $display("FAIL linear_overrun_err: got %b expected 010", b_resp[1]); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (get_resp(1) !== 3'b000) begin n_fail++; $display("FAIL linear_quiet[%0d]: got %b expected 000", k, get_resp(1)); end
        end
    endtask

    task automatic test_err_rty();
        int lat;
        logic [2:0] r;
        logic [31:0] d;
        classic(1, 1'b1, BASE + 32'd2, 32'hFFFF_FFFF, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b010 || lat !== 1) begin n_fail++; $display("FAIL misaligned_err: resp %b lat %0d expected 010 lat 1", r, lat); end
        rty_req[1] = 1'b1;
        classic(1, 1'b1, BASE + 32'd4, 32'hFFFF_FFFF, 4'hF, lat, r, d);
        rty_req[1] = 1'b0;
        n_checks++;
        if (r !== 3'b001 || lat !== 1) begin n_fail++; $display("FAIL retry_resp: resp %b lat %0d expected 001 lat 1", r, lat); end
        classic(1, 1'b0, BASE + 32'd4, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b100 || d !== 32'hC0DE_1111) begin n_fail++; $display("FAIL retry_no_write: resp %b data %h expected 100 data c0de1111", r, d); end
        classic(1, 1'b0, BASE, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (d !== 32'hC0DE_0000) begin n_fail++; $display("FAIL misaligned_no_write: got %h expected c0de0000", d); end
        classic(1, 1'b0, BASE + 32'd64, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b010) begin n_fail++; $display("FAIL above_range_err: got %b expected 010", r); end
        classic(1, 1'b0, BASE - 32'd4, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b010) begin n_fail++; $display("FAIL below_range_err: got %b expected 010", r); end
        classic(0, 1'b0, BASE + 32'd64, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b010 || lat !== 1) begin n_fail++; $display("FAIL ws2_err_latency: resp %b lat %0d expected 010 lat 1", r, lat); end
    endtask

    task automatic test_cyc_drop();
        int lat;
        logic [2:0] r;
        logic [31:0] d;
        logic quiet;
        classic(2, 1'b1, BASE + 32'd20, 32'h5555_5555, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b100 || lat !== 4) begin n_fail++; $display("FAIL ws3_write: resp %b lat %0d expected 100 lat 4", r, lat); end
        adr[2] = BASE + 32'd20; dat_w[2] = 32'h0BAD_0BAD; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (get_resp(2) !== 3'b000) quiet = 1'b0;
        end
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (get_resp(2) !== 3'b000) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL cyc_drop_quiet: got %b expected 1", quiet); end
        classic(2, 1'b0, BASE + 32'd20, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b100 || lat !== 4 || d !== 32'h5555_5555) begin
            n_fail++; $display("FAIL cyc_drop_unchanged: resp %b lat %0d data %h expected 100 lat 4 data 55555555", r, lat, d);
        end
        classic(2, 1'b1, BASE + 32'd20, 32'h6666_6666, 4'hF, lat, r, d);
        classic(2, 1'b0, BASE + 32'd20, 32'h0, 4'hF, lat, r, d);
        n_checks++;
        if (r !== 3'b100 || d !== 32'h6666_6666) begin n_fail++; $display("FAIL cyc_drop_recover: resp %b data %h expected 100 data 66666666", r, d); end
    endtask

    task automatic test_back_to_back();
        adr[1] = BASE + 32'd8; we[1] = 1'b0; sel[1] = 4'hF; cti[1] = 3'b000;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (get_resp(1) !== 3'b100 || dout[1] !== 32'hC0DE_2222) begin
            n_fail++; $display("FAIL b2b_first: resp %b data %h expected 100 data c0de2222", get_resp(1), dout[1]);
        end
        @(posedge clk); #1;
        adr[1] = BASE + 32'd12;
        n_checks++;
        if (get_resp(1) !== 3'b000) begin n_fail++; $display("FAIL b2b_gap: got %b expected 000", get_resp(1)); end
        @(posedge clk); #1;
        n_checks++;
        if (get_resp(1) !== 3'b100 || dout[1] !== 32'hC0DE_3333) begin
            n_fail++; $display("FAIL b2b_second: resp %b data %h expected 100 data c0de3333", get_resp(1), dout[1]);
        end
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        idle_all();
        test_reset();
        test_classic_ws2();
        test_wrap_burst();
        test_linear_end();
        test_err_rty();
        test_cyc_drop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
